ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB slave endpoint downstream of the ahb_intf slave bus (HADDR_S/HTRANS_S/... -> HREADY_S/HRDATA_S/HRESP_S).
//  Decodes NONSEQ/SEQ transfers into a byte-lane-enabled word SRAM; returns OKAY or a two-cycle ERROR.
//  Serves as the DUT-side slave consumed by the slave driver/monitor and checked by the interface SVA.
// PARAMETERS
//  ADDR_W       10          word-address bits; memory = 2**ADDR_W x 32b words
//  BASE_ADDR    32'h0       slave base; HADDR[31:ADDR_W+2] must equal BASE_ADDR[31:ADDR_W+2]
//  WAIT_CYCLES  2           wait states per data phase (only with AHB_SLV_WAIT_EN), 0..15
// PORTS
//  HCLK       in   1   bus clock, all state on posedge
//  HRESET     in   1   asynchronous, active-high reset
//  HSEL       in   1   slave select (address phase)
//  HADDR      in   32  address
//  HTRANS     in   2   0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  HWRITE     in   1   1 write, 0 read
//  HSIZE      in   3   transfer size (0 byte, 1 half, 2 word)
//  HBURST     in   3   burst type; informational, not decoded
//  HWDATA     in   32  write data (data phase)
//  HREADY     in   1   bus-level ready (end of previous data phase)
//  HREADY_OUT out  1   this slave's ready
//  HRDATA     out  32  read data
//  HRESP      out  2   0 OKAY, 1 ERROR (RETRY/SPLIT never issued)
// BEHAVIOUR
//  - Reset: state IDLE, HREADY_OUT=1, HRESP=0, HRDATA=0, pending controls cleared; SRAM content not reset.
//  - Accept: HSEL && HREADY && HTRANS[1] at posedge -> latch addr/write/size, enter data phase next cycle.
//  - IDLE/BUSY or !HSEL: no access; following cycle OKAY, HREADY_OUT=1, zero wait.
//  - Error check at accept: HSIZE>2, HSIZE=1 && HADDR[0], HSIZE=2 && HADDR[1:0]!=0, or base mismatch.
//  - FSM: IDLE -> DATA (ok transfer) | ERR1 (error transfer); DATA -> WAIT when wait count>0;
//    WAIT -> DATA when counter reaches 0; ERR1 -> ERR2 -> IDLE, or DATA/ERR1 on new accept.
//  - DATA: HREADY_OUT=1, HRESP=0; a pipelined accept in the same cycle is taken (back-to-back, no bubble).
//  - ERR1: HREADY_OUT=0, HRESP=1. ERR2: HREADY_OUT=1, HRESP=1. No memory write; HRDATA=0.
//  - Write commits at posedge ending the data phase (HREADY_OUT=1) with byte enables from size/addr[1:0],
//    little-endian lanes; HWDATA taken on the matching lanes.
//  - Read: HRDATA = mem[addr_q] (all 32b) while read data phase with HREADY_OUT=1, else 0.
//  - Write to A followed by read of A: read data phase returns the new data (commit precedes read).
//  - HRESET asserted mid-transfer: immediate return to reset values, pending write dropped.
// CONFIGURATION
//  - AHB_SLV_WAIT_EN defined: each ok data phase holds HREADY_OUT=0, HRESP=0 for WAIT_CYCLES cycles
//    (4-bit down-counter loaded at accept), then one HREADY_OUT=1 cycle; no accept while low.
//  - Undefined: WAIT state/counter removed, every ok data phase zero-wait; WAIT_CYCLES ignored.
// STRUCTURE
//  - ahb_pkg: htrans_e, hresp_e, hsize_e enums; HRESP_OKAY/HRESP_ERROR constants; slv_state_e.
//  - One sub-module: ahb_sram_slave_mem (2**ADDR_W x 32b, 4-bit byte-enable write, async read).
// TESTING
//  - Word write 0xDEADBEEF @0x10, then read @0x10 -> HRDATA=0xDEADBEEF, HRESP=0, zero wait.
//  - Byte writes 0x11,0x22 @0x21,0x23 over 0 -> read @0x20 word returns 0x22001100.
//  - HSIZE=2 @0x02 -> ERR1 (HREADY_OUT=0,HRESP=1) then ERR2 (1,1); read @0x00 returns unchanged.
//  - INCR4 word write 0x40..0x4C back-to-back -> 4 data phases, no bubbles; readback matches.
//  - AHB_SLV_WAIT_EN, WAIT_CYCLES=2: read -> HREADY_OUT low exactly 2 cycles, data on 3rd.
//  - HRESET asserted in WAIT of write @0x80 -> HREADY_OUT=1,HRESP=0 at once; @0x80 unmodified.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM states and the size/offset to byte-lane helper
// used by ahb_sram_slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'd0,
        RESP_ERROR = 2'd1,
        RESP_RETRY = 2'd2,
        RESP_SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    localparam hresp_e HRESP_OKAY  = RESP_OKAY;
    localparam hresp_e HRESP_ERROR = RESP_ERROR;

    // Little-endian lane enables; callers only pass aligned sizes <= word.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = 4'b0011 << {off[1], 1'b0};
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word SRAM for ahb_sram_slave: per-byte write enables on a clock edge,
// asynchronous read of the same word address.
module ahb_sram_slave_mem #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);
    logic [31:0] mem_q [2**ADDR_W];

    // NOTE: the array has no reset branch; resetting it would turn the RAM into flops.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave in front of a byte-lane word SRAM: OKAY transfers, two-cycle ERROR responses.
// Define AHB_SLV_WAIT_EN to insert WAIT_CYCLES wait states into every OK data phase.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADY_OUT,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP
);
    slv_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [3:0]        be_q, be_d;
    logic              accept;
    logic              xfer_err;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic              unused_hburst;
`ifdef AHB_SLV_WAIT_EN
    logic [3:0]        cnt_q, cnt_d;
`else
    localparam int unsigned unused_wait_cycles = WAIT_CYCLES;
`endif

    assign unused_hburst = ^HBURST;

    assign accept = HSEL && HREADY && HREADY_OUT &&
                    (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ);

    assign xfer_err = (HSIZE > SIZE_WORD)
                   || (HSIZE == SIZE_HALF && HADDR[0])
                   || (HSIZE == SIZE_WORD && HADDR[1:0] != 2'b00)
                   || (HADDR[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);

    // NOTE: state and controls update with <= so every flop samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            be_q    <= '0;
`ifdef AHB_SLV_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            be_q    <= be_d;
`ifdef AHB_SLV_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // NOTE: every comb output is defaulted first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        be_d    = be_q;
`ifdef AHB_SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = HADDR[ADDR_W+1:2];
                    write_d = HWRITE;
                    be_d    = byte_en(HSIZE, HADDR[1:0]);
                    if (xfer_err) begin
                        state_d = ST_ERR1;
                    end
`ifdef AHB_SLV_WAIT_EN
                    else if (WAIT_CYCLES != 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
`endif
                    else begin
                        state_d = ST_DATA;
                    end
                end
            end
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = ST_DATA;
            end
`endif
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADY_OUT = 1'b1;
        HRESP      = HRESP_OKAY;
        HRDATA     = '0;
        unique case (state_q)
            ST_DATA: begin
                if (!write_q) HRDATA = mem_rdata;
            end
            ST_WAIT: HREADY_OUT = 1'b0;
            ST_ERR1: begin
                HREADY_OUT = 1'b0;
                HRESP      = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // The write lands on the edge that closes its data phase, ahead of any following read.
    assign mem_we = (state_q == ST_DATA) && write_q;

    ahb_sram_slave_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (HCLK),
        .we_i    (mem_we),
        .be_i    (be_q),
        .addr_i  (addr_q),
        .wdata_i (HWDATA),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: pipelined AHB master, scoreboard of
// per-transfer responses, and scenario tasks with their own inline checks.
module tb_ahb_sram_slave;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
`ifdef AHB_SLV_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        HCLK   = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL   = 1'b0;
    logic [31:0] HADDR  = '0;
    logic [1:0]  HTRANS = T_IDLE;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE  = '0;
    logic [2:0]  HBURST = '0;
    logic [31:0] HWDATA = '0;
    logic        HREADY_OUT;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;

    ahb_sram_slave #(
        .ADDR_W      (10),
        .BASE_ADDR   (32'h0),
        .WAIT_CYCLES (2)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY_OUT),
        .HREADY_OUT (HREADY_OUT),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct packed {
        logic        write;
        logic        err;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [int];
    int          tests_run = 0;
    int          fails = 0;
    string       cur_test = "";
    logic [31:0] wdata_next = '0;
    int          last_lows = 0;
    int          last_err_lows = 0;
    logic [31:0] last_rdata = '0;

    function automatic logic bench_err(input logic [2:0] size, input logic [31:0] addr);
        return (size > 3'd2) || (size == 3'd1 && addr[0]) ||
               (size == 3'd2 && addr[1:0] != 2'b00) || (addr >= 32'h1000);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int wi = int'(addr >> 2);
        return model_mem.exists(wi) ? model_mem[wi] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata);
        logic [31:0] word = model_read(addr);
        int first = int'(addr[1:0]);
        for (int k = 0; k < (1 << size); k++) begin
            word[8*(first+k) +: 8] = wdata[8*(first+k) +: 8];
        end
        model_mem[int'(addr >> 2)] = word;
    endtask

    // One bus cycle seen from the master: present an address phase, let the pending
    // data phase finish (scoreboard pop), then record the new transfer if accepted.
    task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                             input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
        exp_t e;
        int   lows = 0;
        int   err_lows = 0;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        HWDATA = wdata_next;
        while (HREADY_OUT !== 1'b1 && lows < 32) begin
            lows++;
            if (HRESP === 2'b01) err_lows++;
            @(posedge HCLK);
            #1;
        end
        if (lows >= 32) begin
            tests_run++;
            fails++;
            $display("FAIL %s: HREADY_OUT stuck low for %0d cycles, required high", cur_test, lows);
        end
        last_lows     = lows;
        last_err_lows = err_lows;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            last_rdata = HRDATA;
            tests_run++;
            if (HRDATA !== e.rdata || HRESP !== e.resp) begin
                fails++;
                $display("FAIL %s: %s @%h got HRDATA=%h HRESP=%0d, expected HRDATA=%h HRESP=%0d",
                         cur_test, e.write ? "write" : "read", e.addr, HRDATA, HRESP,
                         e.rdata, e.resp);
            end
            if (e.write && !e.err) model_write(e.addr, e.size, e.wdata);
        end
        @(posedge HCLK);
        #1;
        if (sel && trans[1]) begin
            e.write = wr;
            e.err   = bench_err(size, addr);
            e.size  = size;
            e.addr  = addr;
            e.wdata = wdata;
            e.resp  = e.err ? 2'b01 : 2'b00;
            e.rdata = (e.err || wr) ? 32'h0 : model_read(addr);
            sb_q.push_back(e);
        end
        wdata_next = wdata;
    endtask

    task automatic idle_cycle();
        bus_cycle(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        cur_test = "reset";
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        tests_run++;
        if (HREADY_OUT !== 1'b1) begin
            fails++;
            $display("FAIL reset_hready: got %b, expected 1", HREADY_OUT);
        end
        tests_run++;
        if (HRESP !== 2'b00) begin
            fails++;
            $display("FAIL reset_hresp: got %0d, expected 0", HRESP);
        end
        tests_run++;
        if (HRDATA !== 32'h0) begin
            fails++;
            $display("FAIL reset_hrdata: got %h, expected 0", HRDATA);
        end
        HRESET = 1'b0;
    endtask

    task automatic test_word();
        cur_test = "word";
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h00, 32'hCAFEF00D);
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
        idle_cycle();
        tests_run++;
        if (last_rdata !== 32'hDEADBEEF || last_lows != EXP_WAIT) begin
            fails++;
            $display("FAIL word_read: got %h after %0d waits, expected deadbeef after %0d",
                     last_rdata, last_lows, EXP_WAIT);
        end
        // BUSY and unselected NONSEQ must neither respond nor write.
        cur_test = "no_access";
        bus_cycle(1'b1, T_BUSY, 1'b1, 3'd2, 32'h10, 32'h0BAD0BAD);
        tests_run++;
        if (HREADY_OUT !== 1'b1 || HRESP !== 2'b00) begin
            fails++;
            $display("FAIL busy_resp: got ready=%b resp=%0d, expected 1/0", HREADY_OUT, HRESP);
        end
        bus_cycle(1'b0, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0BAD0BAD);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
        idle_cycle();
        tests_run++;
        if (last_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL unselected_write: got %h, expected deadbeef", last_rdata);
        end
    endtask

    task automatic test_bytes();
        cur_test = "bytes";
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h20, 32'h0);
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h21, 32'h11111111);
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h23, 32'h22222222);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
        idle_cycle();
        tests_run++;
        if (last_rdata !== 32'h22001100) begin
            fails++;
            $display("FAIL byte_lanes: got %h, expected 22001100", last_rdata);
        end
        cur_test = "half";
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h30, 32'h0);
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h32, 32'h5A5A5A5A);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h30, 32'h0);
        idle_cycle();
        tests_run++;
        if (last_rdata !== 32'h5A5A0000) begin
            fails++;
            $display("FAIL half_lanes: got %h, expected 5a5a0000", last_rdata);
        end
    endtask

    task automatic test_error();
        cur_test = "error";
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h02, 32'hFFFFFFFF);
        idle_cycle();
        tests_run++;
        if (last_lows != 1 || last_err_lows != 1) begin
            fails++;
            $display("FAIL err1_phase: got %0d low cycles (%0d with ERROR), expected 1 (1)",
                     last_lows, last_err_lows);
        end
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h00, 32'h0);
        idle_cycle();
        tests_run++;
        if (last_rdata !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL err_no_write: got %h, expected cafef00d", last_rdata);
        end
        // Back-to-back error causes, each new request accepted during ERR2.
        cur_test = "error_mix";
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 3'd3, 32'h14, 32'h0);
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h1010, 32'hFFFFFFFF);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
        idle_cycle();
        tests_run++;
        if (last_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL read_after_err: got %h, expected deadbeef", last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int elapsed;
        cur_test = "incr4";
        HBURST = 3'b011;
        start = cyc;
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h40, 32'hA0A0A040);
        bus_cycle(1'b1, T_SEQ,    1'b1, 3'd2, 32'h44, 32'hB1B1B144);
        bus_cycle(1'b1, T_SEQ,    1'b1, 3'd2, 32'h48, 32'hC2C2C248);
        bus_cycle(1'b1, T_SEQ,    1'b1, 3'd2, 32'h4C, 32'hD3D3D34C);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h40, 32'h0);
        bus_cycle(1'b1, T_SEQ,    1'b0, 3'd2, 32'h44, 32'h0);
        bus_cycle(1'b1, T_SEQ,    1'b0, 3'd2, 32'h48, 32'h0);
        bus_cycle(1'b1, T_SEQ,    1'b0, 3'd2, 32'h4C, 32'h0);
        idle_cycle();
        elapsed = cyc - start;
        HBURST = 3'b000;
        tests_run++;
        if (elapsed != 9 + 8 * EXP_WAIT) begin
            fails++;
            $display("FAIL incr4_cycles: got %0d cycles, expected %0d", elapsed, 9 + 8 * EXP_WAIT);
        end
        tests_run++;
        if (last_rdata !== 32'hD3D3D34C) begin
            fails++;
            $display("FAIL incr4_last: got %h, expected d3d3d34c", last_rdata);
        end
    endtask

    task automatic test_reset_mid();
        cur_test = "reset_mid";
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h80, 32'h12345678);
        idle_cycle();
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h80, 32'hFFFFFFFF);
`ifdef AHB_SLV_WAIT_EN
        tests_run++;
        if (HREADY_OUT !== 1'b0) begin
            fails++;
            $display("FAIL in_wait: got HREADY_OUT=%b, expected 0", HREADY_OUT);
        end
`endif
        HSEL   = 1'b0;
        HTRANS = T_IDLE;
        HWDATA = 32'hFFFFFFFF;
        HRESET = 1'b1;
        #1;
        tests_run++;
        if (HREADY_OUT !== 1'b1 || HRESP !== 2'b00 || HRDATA !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got ready=%b resp=%0d rdata=%h, expected 1/0/0",
                     HREADY_OUT, HRESP, HRDATA);
        end
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        sb_q.delete();
        wdata_next = '0;
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h80, 32'h0);
        idle_cycle();
        tests_run++;
        if (last_rdata !== 32'h12345678) begin
            fails++;
            $display("FAIL reset_drop_write: got %h, expected 12345678", last_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_bytes();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
